aprx_add_arbiter: RTL and testbench
===================================

# aprx_add_arbiter

Round-robin controller that shares one approximate FP adder (binary16alt or binary8) among N_REQ requesters. It accepts operand pairs over per-requester valid/ready, issues them one per cycle into the shared adder, and tracks a tag pipeline matched to the adder's latency. Each result is returned in a per-requester response register with valid/ready. It sits between the transprecision cores' FP issue ports and the single adder instance.

## Interface
- N_REQ, 4, number of requesters (2..8)
- SIZE, 16, operand/result width: 16 = binary16alt, 8 = binary8
- ADD_LAT, 0, register stages inside the shared adder (0 = combinational)
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  N_REQ  requester i presents an operand pair
- req_ready  out  N_REQ  grant; pair accepted on req_valid[i] & req_ready[i]
- req_a, req_b  in  N_REQ x SIZE  operands per requester
- rsp_valid  out  N_REQ  result available for requester i
- rsp_ready  in  N_REQ  requester i consumes its result
- rsp_c  out  N_REQ x SIZE  result per requester
- add_a, add_b  out  SIZE  registered operands to the shared adder
- add_c  in  SIZE  adder result, valid ADD_LAT cycles after add_a/add_b

## Operation
- busy[i] set on accept for requester i; cleared at the edge where rsp_valid[i] & rsp_ready[i]. A busy requester is never granted, so each requester has at most one operation outstanding. Responses therefore never stall the pipeline.
- Eligibility: elig[i] = req_valid[i] & !busy[i].
- Arbitration is round-robin:
  - ptr is in 0..N_REQ-1 and resets to 0.
  - Grant goes to the first eligible index at or after ptr, wrapping.
  - At most one grant per cycle.
  - After a grant to i, ptr <= (i+1) mod N_REQ. With no grant, ptr holds.
- req_ready is combinational from req_valid and busy. It is one-hot or zero.
- Issue stage: on grant, add_a/add_b <= req_a[i]/req_b[i], and the tag pipeline stage 0 <= {1, i}. With no grant, the stage-0 valid bit is 0 and add_a/add_b hold.
- The tag pipeline has ADD_LAT+1 stages of {valid, idx}. When the last stage is valid, rsp_c[idx] <= add_c and rsp_valid[idx] <= 1.
- rsp_valid[i] stays high, and rsp_c[i] stays stable, until rsp_ready[i].
- No arithmetic in this block. Operands pass through bit-exact and results are captured bit-exact.
- Reset while operations are in flight:
  - All in-flight operations are discarded.
  - busy, tag valids, rsp_valid, and ptr go to 0.
  - add_a, add_b, and rsp_c go to 0.

## Timing
- Reset values: req_ready 0 while rst is high, then combinational. rsp_valid 0. rsp_c 0. add_a/add_b 0.
- Accept in cycle t, so add_a/add_b are valid in cycle t+1. add_c is sampled at the end of cycle t+1+ADD_LAT. rsp_valid rises in cycle t+2+ADD_LAT. With ADD_LAT = 0, latency is 2 cycles.
- Throughput is one issue per cycle across requesters. Each requester gets one operation per round trip, plus 1 cycle after its response handshake before it is eligible again.
- A response handshake and a new request from the same requester in the same cycle: no grant that cycle. The requester is eligible the next cycle.
- A result written to slot j in the same cycle that requester j handshakes cannot occur, because busy[j] guarantees it.

## Structure
- Package aprx_fpu_pkg:
  - Width constants FP16ALT_W = 16 and FP8_W = 8.
  - Format fields: binary16alt = 1/8/7, binary8 = 1/5/2.
  - Function clog2-based IDX_W.
  - Tag struct {logic valid; logic [IDX_W-1:0] idx}.
- Sub-module rr_arbiter (N parameter): inputs elig and advance; outputs a one-hot grant; holds ptr internally.
- The tag pipeline, busy flags, and response registers stay in aprx_add_arbiter.

## Test plan
- Single op, SIZE = 16, ADD_LAT = 0, stub adder = aprx_add: requester 0 sends a = 0x3F80 (1.0), b = 0x4000 (2.0) at t. Required: rsp_valid[0] at t+2, rsp_c[0] = 0x4040, held until rsp_ready[0].
- Contention: all 4 requesters valid from reset release. Required: grants in order 0, 1, 2, 3 on consecutive cycles. Responses arrive on consecutive cycles, each tagged to the correct slot.
- Round-robin fairness: requesters 1 and 3 always valid, responses consumed immediately. Required: grants alternate 1, 3, 1, 3 with no starvation.
- One outstanding limit: requester 2 holds rsp_ready[2] = 0 for 10 cycles while req_valid[2] = 1. Required: req_ready[2] stays 0 until 1 cycle after the handshake. Other requesters are unaffected.
- Latency parameter: ADD_LAT = 3 with a pipelined adder model. Required: rsp_valid 5 cycles after accept; back-to-back issues return in order.
- Reset mid-flight: assert rst with 3 operations in flight. Required: all outputs are 0 immediately, no rsp_valid after release, and ptr = 0 (first grant after release goes to the lowest valid index).

Source files
------------

// File: rtl/aprx_fpu_pkg.sv
// Shared types and constants for the transprecision FP adder sharing logic.
package aprx_fpu_pkg;

    // Format fields: sign / exponent / mantissa
    localparam int unsigned FP16ALT_EXP_W = 8;
    localparam int unsigned FP16ALT_MAN_W = 7;
    localparam int unsigned FP8_EXP_W     = 5;
    localparam int unsigned FP8_MAN_W     = 2;

    localparam int unsigned FP16ALT_W = 1 + FP16ALT_EXP_W + FP16ALT_MAN_W;
    localparam int unsigned FP8_W     = 1 + FP8_EXP_W + FP8_MAN_W;

    // Largest supported requester count; tag index is sized for it
    localparam int unsigned MAX_REQ = 8;

    // Index width for n requesters (at least one bit)
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned IDX_W = idx_w(MAX_REQ);

    // One stage of the tag pipeline that shadows the shared adder
    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/aprx_add_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first eligible index at or after ptr.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] elig,
    input  logic         advance,
    output logic [N-1:0] grant_c
);

    localparam int unsigned PW = (N > 2) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] win_c;
    logic [PW-1:0] pos_c;
    logic          found_c;

    // Search from ptr with wrap-around; ptr moves just past the winner
    always_comb begin
        grant_c = '0;
        win_c   = ptr_q;
        pos_c   = ptr_q;
        found_c = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            pos_c = PW'((32'(ptr_q) + k) % N);
            if (!found_c && elig[pos_c]) begin
                found_c        = 1'b1;
                win_c          = pos_c;
                grant_c[pos_c] = 1'b1;
            end
        end
        ptr_d = ptr_q;
        if (advance && found_c) begin
            ptr_d = (32'(win_c) == N - 1) ? '0 : PW'(32'(win_c) + 32'd1);
        end
    end

    // Pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/aprx_add_arbiter.sv
// Shares one approximate FP adder among N_REQ requesters with per-requester
// response registers and a tag pipeline matched to the adder latency.
module aprx_add_arbiter
    import aprx_fpu_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned SIZE    = FP16ALT_W,
    parameter int unsigned ADD_LAT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ-1:0][SIZE-1:0] req_a,
    input  logic [N_REQ-1:0][SIZE-1:0] req_b,
    output logic [N_REQ-1:0]           rsp_valid,
    input  logic [N_REQ-1:0]           rsp_ready,
    output logic [N_REQ-1:0][SIZE-1:0] rsp_c,
    output logic [SIZE-1:0]            add_a,
    output logic [SIZE-1:0]            add_b,
    input  logic [SIZE-1:0]            add_c
);

    logic [N_REQ-1:0]           elig_c;
    logic [N_REQ-1:0]           grant_c;
    logic                       grant_any_c;
    logic [IDX_W-1:0]           gidx_c;
    logic [N_REQ-1:0]           busy_q, busy_d;
    logic [N_REQ-1:0]           rsp_valid_q, rsp_valid_d;
    logic [N_REQ-1:0][SIZE-1:0] rsp_q, rsp_d;
    logic [SIZE-1:0]            add_a_q, add_a_d;
    logic [SIZE-1:0]            add_b_q, add_b_d;
    tag_t                       tag_q [0:ADD_LAT];
    tag_t                       tag_d [0:ADD_LAT];

    // A requester with a result outstanding is never granted again
    assign elig_c      = req_valid & ~busy_q;
    assign grant_any_c = |grant_c;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .elig    (elig_c),
        .advance (grant_any_c),
        .grant_c (grant_c)
    );

    assign req_ready = rst ? '0 : grant_c;
    assign rsp_valid = rsp_valid_q;
    assign rsp_c     = rsp_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;

    // One-hot grant to index for the issue tag
    always_comb begin
        gidx_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_c[i]) begin
                gidx_c = IDX_W'(i);
            end
        end
    end

    // Issue, tag shift, busy tracking and response capture
    always_comb begin
        busy_d      = busy_q;
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;

        tag_d[0] = '{valid: grant_any_c, idx: gidx_c};
        for (int s = 1; s <= int'(ADD_LAT); s++) begin
            tag_d[s] = tag_q[s-1];
        end

        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_c[i]) begin
                add_a_d   = req_a[i];
                add_b_d   = req_b[i];
                busy_d[i] = 1'b1;
            end
            // Set and clear are exclusive: a slot only fills while busy and unconsumed
            if (rsp_valid_q[i] && rsp_ready[i]) begin
                busy_d[i]      = 1'b0;
                rsp_valid_d[i] = 1'b0;
            end
            if (tag_q[ADD_LAT].valid && (tag_q[ADD_LAT].idx == IDX_W'(i))) begin
                rsp_valid_d[i] = 1'b1;
                rsp_d[i]       = add_c;
            end
        end
    end

    // State registers; reset discards everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= '0;
            rsp_valid_q <= '0;
            rsp_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            for (int s = 0; s <= int'(ADD_LAT); s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            for (int s = 0; s <= int'(ADD_LAT); s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

endmodule

// File: tb/tb_aprx_add_arbiter.sv
// Bench: two instances (combinational adder and 3-stage adder) driven with the
// same stimulus, each checked against its own round-robin/scoreboard model.
module tb_aprx_add_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    typedef struct {
        int          idx;
        logic [15:0] val;
        int          due;
    } exp_t;

    logic                    clk;
    logic                    rst;
    logic [N-1:0]            req_valid;
    logic [N-1:0]            rsp_ready;
    logic [N-1:0][W-1:0]     req_a;
    logic [N-1:0][W-1:0]     req_b;
    logic [N-1:0]            rdy  [2];
    logic [N-1:0]            rspv [2];
    logic [N-1:0][W-1:0]     rspc [2];
    logic [W-1:0]            adda [2];
    logic [W-1:0]            addb [2];
    logic [W-1:0]            addc [2];
    logic [W-1:0]            pipe1 [3];

    int          lat [2] = '{0, 3};
    exp_t        sbq [2][$];
    int          ptr_m [2];
    bit          busy_m [2][N];
    bit          rvm [2][N];
    logic [15:0] held [2][N];
    logic [15:0] xa [2];
    logic [15:0] xb [2];
    int          cyc   = 0;
    int          n_vec = 0;
    int          n_err = 0;

    // Truncating bfloat16 add for positive normal operands
    function automatic logic [15:0] bf_add(input logic [15:0] a, input logic [15:0] b);
        logic [7:0] ea, eb, d;
        logic [7:0] ma, mb;
        logic [8:0] s;
        if (a[14:7] >= b[14:7]) begin
            ea = a[14:7]; ma = {1'b1, a[6:0]};
            eb = b[14:7]; mb = {1'b1, b[6:0]};
        end else begin
            ea = b[14:7]; ma = {1'b1, b[6:0]};
            eb = a[14:7]; mb = {1'b1, a[6:0]};
        end
        d = ea - eb;
        s = {1'b0, ma} + ({1'b0, mb} >> d);
        if (s[8]) return {1'b0, ea + 8'd1, s[7:1]};
        return {1'b0, ea, s[6:0]};
    endfunction

    function automatic logic [15:0] rnd_fp();
        return {1'b0, 8'(120 + $urandom_range(0, 14)), 7'($urandom)};
    endfunction

    aprx_add_arbiter #(.N_REQ(N), .SIZE(W), .ADD_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rspv[0]), .rsp_ready(rsp_ready),
        .rsp_c(rspc[0]), .add_a(adda[0]), .add_b(addb[0]), .add_c(addc[0])
    );

    aprx_add_arbiter #(.N_REQ(N), .SIZE(W), .ADD_LAT(3)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rspv[1]), .rsp_ready(rsp_ready),
        .rsp_c(rspc[1]), .add_a(adda[1]), .add_b(addb[1]), .add_c(addc[1])
    );

    // Stub adders: combinational, and a 3-register pipeline
    assign addc[0] = bf_add(adda[0], addb[0]);
    always @(posedge clk) begin
        pipe1[0] <= bf_add(adda[1], addb[1]);
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign addc[1] = pipe1[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_zero(input int d);
        chk("rst_req_ready", rdy[d], 0);
        chk("rst_rsp_valid", rspv[d], 0);
        chk("rst_rsp_c", rspc[d], 0);
        chk("rst_add_a", adda[d], 0);
        chk("rst_add_b", addb[d], 0);
    endtask

    // Model: predicts the grant, pushes expected results, pops on presentation
    task automatic check_dut(input int d);
        int           g;
        int           idx;
        logic [N-1:0] eg;
        exp_t         e;
        if (rst) begin
            chk_zero(d);
            ptr_m[d] = 0;
            xa[d] = '0;
            xb[d] = '0;
            sbq[d].delete();
            for (int i = 0; i < N; i++) begin
                busy_m[d][i] = 1'b0;
                rvm[d][i] = 1'b0;
            end
            return;
        end
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (ptr_m[d] + k) % N;
            if (g < 0 && req_valid[idx] && !busy_m[d][idx]) g = idx;
        end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("grant", rdy[d], eg);
        chk("add_a", adda[d], xa[d]);
        chk("add_b", addb[d], xb[d]);

        for (int i = 0; i < N; i++) begin
            if (rspv[d][i] && !rvm[d][i]) begin
                if (sbq[d].size() == 0) begin
                    chk("rsp_spurious", rspv[d][i], 0);
                end else begin
                    e = sbq[d].pop_front();
                    chk("rsp_slot", i, e.idx);
                    chk("rsp_data", rspc[d][i], e.val);
                    chk("rsp_cycle", cyc, e.due);
                    held[d][i] = e.val;
                    rvm[d][i] = 1'b1;
                end
            end else if (rvm[d][i]) begin
                chk("rsp_hold_valid", rspv[d][i], 1);
                chk("rsp_hold_data", rspc[d][i], held[d][i]);
            end
        end
        if (sbq[d].size() > 0 && sbq[d][0].due < cyc) begin
            chk("rsp_missing", rspv[d][sbq[d][0].idx], 1);
            void'(sbq[d].pop_front());
        end

        if (g >= 0) begin
            busy_m[d][g] = 1'b1;
            ptr_m[d] = (g + 1) % N;
            e.idx = g;
            e.val = bf_add(req_a[g], req_b[g]);
            e.due = cyc + 2 + lat[d];
            sbq[d].push_back(e);
            xa[d] = req_a[g];
            xb[d] = req_b[g];
        end
        for (int i = 0; i < N; i++) begin
            if (rvm[d][i] && rsp_ready[i]) begin
                rvm[d][i] = 1'b0;
                busy_m[d][i] = 1'b0;
            end
        end
    endtask

    // Monitor runs on the falling edge, away from the active edge
    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) check_dut(d);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i] = rnd_fp();
            req_b[i] = rnd_fp();
        end
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        rsp_ready = '1;
        repeat (n) step();
    endtask

    initial begin
        logic [N-1:0] prev;
        int           ng;

        rst = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        rand_ops();
        repeat (3) step();

        // Contention: everyone valid from reset release
        req_valid = '1;
        rsp_ready = '1;
        step();
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            chk("contention_grant0", rdy[0], 4'b0001 << k);
            chk("contention_grant1", rdy[1], 4'b0001 << k);
            rand_ops();
            step();
        end
        repeat (8) begin rand_ops(); step(); end

        // Single op 1.0 + 2.0 on requester 0
        idle(10);
        req_valid = 4'b0001;
        rsp_ready = 4'b0000;
        req_a[0] = 16'h3F80;
        req_b[0] = 16'h4000;
        @(negedge clk);
        chk("single_grant", rdy[0], 4'b0001);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("single_not_yet", rspv[0][0], 0);
        step();
        @(negedge clk);
        chk("single_valid", rspv[0][0], 1);
        chk("single_data", rspc[0][0], 16'h4040);
        repeat (3) step();
        @(negedge clk);
        chk("single_held_valid", rspv[0][0], 1);
        chk("single_held_data", rspc[0][0], 16'h4040);
        rsp_ready = '1;
        step();

        // Fairness between requesters 1 and 3
        idle(10);
        req_valid = 4'b1010;
        prev = '0;
        ng = 0;
        repeat (18) begin
            rand_ops();
            @(negedge clk);
            if (rdy[0] != '0) begin
                if (prev != '0) chk("fair_alternate", rdy[0], (prev == 4'b0010) ? 4'b1000 : 4'b0010);
                prev = rdy[0];
                ng++;
            end
            step();
        end
        chk("fair_grant_count", (ng >= 10), 1);

        // One outstanding: requester 2 withholds rsp_ready
        idle(10);
        req_valid = '1;
        rsp_ready = 4'b1011;
        repeat (4) begin rand_ops(); step(); end
        repeat (8) begin
            rand_ops();
            @(negedge clk);
            chk("outstanding_hold0", rdy[0][2], 0);
            chk("outstanding_hold1", rdy[1][2], 0);
            step();
        end
        rsp_ready = '1;
        repeat (6) begin rand_ops(); step(); end

        // Random traffic
        idle(10);
        repeat (400) begin
            req_valid = N'($urandom);
            rsp_ready = N'($urandom | $urandom);
            rand_ops();
            step();
        end

        // Reset with operations in flight
        idle(10);
        req_valid = '1;
        rsp_ready = '0;
        repeat (3) begin rand_ops(); step(); end
        rst = 1'b1;
        #1;
        chk_zero(0);
        chk_zero(1);
        req_valid = '0;
        repeat (2) step();
        req_valid = 4'b0110;
        rsp_ready = '1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_grant0", rdy[0], 4'b0010);
        chk("post_reset_grant1", rdy[1], 4'b0010);
        step();
        idle(12);

        for (int d = 0; d < 2; d++) chk("scoreboard_drained", sbq[d].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
